seq_bit_serializer: RTL



---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_hold_buf.sv | 41 ++++
 rtl/seq_bit_serializer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the 1011 sequence detector it feeds.
// Holds the serializer FSM encoding, the default word width and the detector
// state encoding so both blocks (and their benches) agree on the same values.
package seq_pkg;

    // Default parallel word width.
    localparam int SEQ_WORD_W = 8;

    // Serializer FSM: waiting for a word, or streaming one out.
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // 1011 detector states, named after the longest matched prefix.
    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_1    = 2'd1,
        DET_10   = 2'd2,
        DET_101  = 2'd3
    } det_state_t;

endpackage

// File: rtl/seq_hold_buf.sv
// One-entry valid/ready holding register.
// A word is captured when push is seen while empty; pop empties it.
// ready depends only on the stored flag, never on push, so upstream logic
// can use it without creating a combinational loop.
module seq_hold_buf
    import seq_pkg::*;
#(
    parameter int WIDTH = SEQ_WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             push,
    output logic             ready,
    input  logic             pop,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    // Capture on an accepted push, release on pop; the two never coincide
    // because a push is only accepted while empty and a pop needs a full entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (push && !valid_reg) begin
            data_reg  <= data;
            valid_reg <= 1'b1;
        end else if (pop) begin
            valid_reg <= 1'b0;
        end
    end

    assign ready = !valid_reg;
    assign q     = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the 1011 sequence detector.
// Words arrive on a valid/ready handshake into a one-word holding buffer and
// are shifted out one bit per enabled clock. A word waiting in the buffer is
// loaded in the same edge that consumes the last bit of the current one, so
// back-to-back words stream without a gap.
// Build option: define SEQ_SER_PARITY_EN to append an even-parity bit
// (XOR of the word) after each word's data bits.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_WORD_W,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             first_bit,
    output logic             last_bit
);

    localparam int CNT_W   = $clog2(WIDTH + 1);
    // Index of the shift-register bit that is presented next.
    localparam int OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;
`ifdef SEQ_SER_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH);
`else
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WIDTH - 1);
`endif

    ser_state_t       state_reg;
    logic [WIDTH-1:0] sh_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ser_bit_reg;
    logic             ser_valid_reg;
    logic             first_reg;
    logic             last_reg;
`ifdef SEQ_SER_PARITY_EN
    logic             par_reg;
`endif

    logic [WIDTH-1:0] hold_q;
    logic             hold_valid;
    logic             load;
    logic [WIDTH-1:0] sh_next;
    logic [CNT_W-1:0] cnt_next;
    logic             bit_next;

    seq_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk   (clk),
        .reset (reset),
        .data  (din),
        .push  (din_valid),
        .ready (din_ready),
        .pop   (load),
        .q     (hold_q),
        .valid (hold_valid)
    );

    // Load decision plus the shifted word and the bit presented after a shift.
    always_comb begin
        load     = hold_valid &&
                   ((state_reg == SER_IDLE) || (ser_en && (cnt_reg == LAST_CNT)));
        sh_next  = (MSB_FIRST != 0) ? {sh_reg[WIDTH-2:0], 1'b0}
                                    : {1'b0, sh_reg[WIDTH-1:1]};
        cnt_next = cnt_reg + CNT_W'(1);
`ifdef SEQ_SER_PARITY_EN
        // After the final data bit the stored parity goes out.
        bit_next = (cnt_reg == DATA_LAST) ? par_reg : sh_next[OUT_IDX];
`else
        bit_next = sh_next[OUT_IDX];
`endif
    end

    // Serializer FSM: load from the buffer, shift on ser_en, drop to idle when drained.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= SER_IDLE;
            sh_reg        <= '0;
            cnt_reg       <= '0;
            ser_bit_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            first_reg     <= 1'b0;
            last_reg      <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_reg       <= 1'b0;
`endif
        end else if (load) begin
            state_reg     <= SER_SHIFT;
            sh_reg        <= hold_q;
            cnt_reg       <= '0;
            ser_bit_reg   <= hold_q[OUT_IDX];
            ser_valid_reg <= 1'b1;
            first_reg     <= 1'b1;
            last_reg      <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_reg       <= ^hold_q;
`endif
        end else if ((state_reg == SER_SHIFT) && ser_en) begin
            if (cnt_reg == LAST_CNT) begin
                // Word finished and nothing waiting: idle outputs a 0 stream.
                state_reg     <= SER_IDLE;
                cnt_reg       <= '0;
                ser_bit_reg   <= 1'b0;
                ser_valid_reg <= 1'b0;
                first_reg     <= 1'b0;
                last_reg      <= 1'b0;
            end else begin
                sh_reg      <= sh_next;
                cnt_reg     <= cnt_next;
                ser_bit_reg <= bit_next;
                first_reg   <= 1'b0;
                last_reg    <= (cnt_next == LAST_CNT);
            end
        end
    end

    assign ser_bit   = ser_bit_reg;
    assign ser_valid = ser_valid_reg;
    assign first_bit = first_reg;
    assign last_bit  = last_reg;

endmodule
